// File: rtl/npc_pkg.sv
// npc_pkg: shared op codes, funct3/fn encodings and FSM states
// for the npc core branch resolution path.
package npc_pkg;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] FN_EQ  = 3'b000;
    localparam logic [2:0] FN_NE  = 3'b001;
    localparam logic [2:0] FN_GE  = 3'b010;
    localparam logic [2:0] FN_LT  = 3'b011;
    localparam logic [2:0] FN_GTU = 3'b100;
    localparam logic [2:0] FN_LTU = 3'b101;
    localparam logic [2:0] FN_GEU = 3'b110;
    localparam logic [2:0] FN_OVF = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Returns {illegal, fn}; funct3 010/011 have no branch meaning.
    function automatic logic [3:0] f3_to_fn(input logic [2:0] f3);
        logic [3:0] r;
        r = {1'b1, FN_EQ};
        unique case (f3)
            F3_BEQ:  r = {1'b0, FN_EQ};
            F3_BNE:  r = {1'b0, FN_NE};
            F3_BLT:  r = {1'b0, FN_LT};
            F3_BGE:  r = {1'b0, FN_GE};
            F3_BLTU: r = {1'b0, FN_LTU};
            F3_BGEU: r = {1'b0, FN_GEU};
            default: r = {1'b1, FN_EQ};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational compare of a against b, selected by fn,
// using the flags of a single a-b subtraction.
module branch_cond
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      fn,
    output logic            cond
);

    logic [XLEN:0] diff;
    logic          zf;
    logic          nf;
    logic          vf;
    logic          cf;

    // a + ~b + 1; the carry out is set exactly when no borrow occurs.
    assign diff = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    assign cf   = diff[XLEN];
    assign nf   = diff[XLEN-1];
    assign zf   = (diff[XLEN-1:0] == '0);
    assign vf   = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);

    // Select the condition from the flag set.
    always_comb begin
        cond = 1'b0;
        unique case (fn)
            FN_EQ:  cond = zf;
            FN_NE:  cond = ~zf;
            FN_GE:  cond = ~(nf ^ vf);
            FN_LT:  cond = nf ^ vf;
            FN_GTU: cond = cf & ~zf;
            FN_LTU: cond = ~cf;
            FN_GEU: cond = cf;
            FN_OVF: cond = vf;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: accepts a branch/jump op, resolves direction,
// target and link, and hands a registered redirect record to IFU.
module branch_resolve_unit
    import npc_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pred_taken_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redir_pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] taken_cnt_o,
    output logic [XLEN-1:0] mispred_cnt_o
);

    state_e          state;
    state_e          state_nxt;
    logic            in_hs;
    logic            out_hs;

    op_e             op_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            pred_q;

    logic [2:0]      fn;
    logic            f3_bad;
    logic            cond;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] res_tgt;
    logic [XLEN-1:0] res_link;
    logic            res_taken;
    logic            res_ill;

    // Flush overrides both handshakes in the same cycle.
    assign in_hs  = in_valid_i & in_ready_o & ~flush_i;
    assign out_hs = out_valid_o & out_ready_i & ~flush_i;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (in_hs) state_nxt = S_EVAL;
            S_EVAL: state_nxt = S_RESP;
            S_RESP: if (out_hs) state_nxt = in_hs ? S_EVAL : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) state_nxt = S_IDLE;
    end

    // FSM outputs; RESP takes a new op only when the record leaves.
    always_comb begin
        in_ready_o  = (state == S_IDLE) | ((state == S_RESP) & out_ready_i);
        out_valid_o = (state == S_RESP);
    end

    // Capture the incoming op on the input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_BRANCH;
            funct3_q <= '0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            pred_q   <= 1'b0;
        end else if (in_hs) begin
            op_q     <= op_e'(op_i);
            funct3_q <= funct3_i;
            pc_q     <= pc_i;
            rs1_q    <= rs1_i;
            rs2_q    <= rs2_i;
            imm_q    <= imm_i;
            pred_q   <= pred_taken_i;
        end
    end

    assign {f3_bad, fn} = f3_to_fn(funct3_q);

    branch_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .a    (rs1_q),
        .b    (rs2_q),
        .fn   (fn),
        .cond (cond)
    );

    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_tgt   = pc_q + imm_q;
    assign jalr_sum = rs1_q + imm_q;

    // Resolve direction, target, link and legality of the captured op.
    always_comb begin
        res_taken = 1'b0;
        res_ill   = 1'b0;
        res_tgt   = br_tgt;
        res_link  = '0;
        unique case (op_q)
            OP_BRANCH: begin
                res_ill   = f3_bad;
                res_taken = cond & ~f3_bad;
            end
            OP_JAL: begin
                res_taken = 1'b1;
                res_link  = pc_plus4;
            end
            OP_JALR: begin
                res_taken = 1'b1;
                res_tgt   = {jalr_sum[XLEN-1:1], 1'b0};
                res_link  = pc_plus4;
            end
            default: res_ill = 1'b1;
        endcase
    end

    // Register the record in EVAL; it then holds until the next EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_o      <= 1'b0;
            mispredict_o <= 1'b0;
            illegal_o    <= 1'b0;
            redir_pc_o   <= RESET_PC_LINK;
            link_o       <= RESET_PC_LINK;
        end else if ((state == S_EVAL) && !flush_i) begin
            taken_o      <= res_taken;
            mispredict_o <= res_taken ^ pred_q;
            illegal_o    <= res_ill;
            redir_pc_o   <= res_taken ? res_tgt : pc_plus4;
            link_o       <= res_link;
        end
    end

    // Saturating perf counters, bumped only by a delivered record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_o   <= '0;
            mispred_cnt_o <= '0;
        end else if (out_hs) begin
            if (taken_o && (taken_cnt_o != '1))
                taken_cnt_o <= taken_cnt_o + XLEN'(1);
            if (mispredict_o && (mispred_cnt_o != '1))
                mispred_cnt_o <= mispred_cnt_o + XLEN'(1);
        end
    end

endmodule
